mem_burst_reader: RTL and testbench
===================================

Name: mem_burst_reader

Overview:
- Read-side master for the team's pseudo-2-port memory: on a start command, walks a contiguous address range through the memory's combinational read port.
- Captures each word into a registered output stage and presents it on a valid/ready stream.
- Sits between an external/internal memory instance and consumers such as PE input feeders.
- Sustains 1 word/cycle under continuous out_ready.

Parameters:
- WIDTH, 16, data word width; must match the attached memory.
- HEIGHT, 256, memory depth in words. ADDR_W = $clog2(HEIGHT) is derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  burst request; sampled only when busy=0.
- base_addr  in  ADDR_W  first word address of the burst.
- length  in  ADDR_W+1  number of words, 0..HEIGHT.
- busy  out  1  high while a burst is in READ or DRAIN.
- done  out  1  single-cycle completion pulse.
- mem_read_addr  out  ADDR_W  connects to the memory read_addr.
- mem_qout  in  WIDTH  connects to the memory qout (0-cycle read).
- out_data  out  WIDTH  streamed word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts a word when out_valid and out_ready are both high at the same edge.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - addr=0, remaining=0, out_valid=0, out_data=0, done=0, busy=0.
  - mem_read_addr=0.
- Reset mid-burst aborts the burst: no done pulse, the pending word is dropped.
- States: IDLE, READ, DRAIN. busy = (state != IDLE).
- mem_read_addr is always the addr register. It holds its last value in IDLE and DRAIN.
- IDLE:
  - start=1 latches addr<=base_addr and remaining<=length.
  - If length==0: stay IDLE and pulse done the next cycle.
  - Otherwise go to READ.
  - start while busy=1 is ignored, with no queuing.
- READ, load condition: load = !out_valid || out_ready.
- READ, on load:
  - out_data<=mem_qout and out_valid<=1.
  - addr<=addr+1, wrapping from HEIGHT-1 to 0.
  - remaining<=remaining-1.
  - If remaining==1 at this edge, go to DRAIN.
- READ, without load: addr, remaining and out_data all hold. out_valid stays 1 (valid/ready rule: data is stable while stalled).
- DRAIN:
  - An edge with out_valid && out_ready gives out_valid<=0 and state<=IDLE.
  - done is 1 in the following cycle; busy is 0 in that same cycle.
  - A new start is accepted in the cycle where done=1.
- done:
  - Registered pulse, exactly 1 cycle wide per accepted burst, including length==0.
- Latency:
  - start sampled at edge E0 puts base_addr on mem_read_addr during cycle E0..E1.
  - The first word appears with out_valid=1 after E1.
  - For a length-N burst with out_ready held at 1: words arrive on N consecutive cycles, and done is asserted 1 cycle after the last handshake.
- Read/write collision: if the memory writes the address currently on mem_read_addr at edge E, the word captured at E is the pre-write value. Coherence is the caller's responsibility.
- Width: remaining is ADDR_W+1 bits so length=HEIGHT is legal. A full-depth burst starting at a nonzero base wraps and reads every word exactly once.

Test Plan:
- Basic burst: preload mem[i]=i+100; start, base=4, length=5, out_ready=1 -> out_data 104,105,106,107,108 on consecutive cycles; done 1 cycle after the last word; busy=0 with done.
- Backpressure: length=3, base=0, out_ready toggling 1,0,0,1,0,1 -> out_data stable and out_valid held during stalls; sequence 100,101,102 with no loss or duplication; mem_read_addr does not advance while stalled.
- Wrap-around: HEIGHT=256, base=254, length=4 -> addresses 254,255,0,1; data 354,355,100,101.
- Zero length and ignored start:
  - length=0 -> done pulse 1 cycle later, out_valid never asserted, busy stays 0.
  - A second start mid-burst is ignored and still yields exactly one done.
- Reset mid-burst: rst=1 after 2 of 6 words -> next cycle out_valid=0, busy=0, mem_read_addr=0, no done; a new burst base=10, length=2 then returns 110,111.
- Collision: the memory writes 0xBEEF to the address being captured at the same edge -> captured word is the old value; a re-read burst returns 0xBEEF.

Source files
------------

// File: rtl/mem_burst_reader_if.sv
// Bundle of every signal between mem_burst_reader and the blocks around it:
// the command side (start/base_addr/length/busy/done), the combinational read
// port of the pseudo-2-port memory (mem_read_addr/mem_qout) and the outgoing
// valid/ready word stream (out_data/out_valid/out_ready).
//   modport master : the burst reader itself
//   modport slave  : the environment (command source, memory, consumer)
interface mem_burst_reader_if #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 256
);
  localparam int ADDR_W = $clog2(HEIGHT);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [WIDTH-1:0]  mem_qout;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, base_addr, length, mem_qout, out_ready,
    output busy, done, mem_read_addr, out_data, out_valid
  );

  modport slave (
    output start, base_addr, length, mem_qout, out_ready,
    input  busy, done, mem_read_addr, out_data, out_valid
  );
endinterface

// File: rtl/mem_burst_reader.sv
// Read-side burst master for the pseudo-2-port memory. A start command in
// IDLE latches a base address and a word count; the block then walks the
// address range through the memory's 0-cycle read port, registers each word
// and presents it on a valid/ready stream at up to one word per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any burst, no done)
//   bus  - mem_burst_reader_if.master (command, memory read port, stream)
module mem_burst_reader #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 256
) (
  input  logic                clk,
  input  logic                rst,
  mem_burst_reader_if.master  bus
);
  localparam int ADDR_W = $clog2(HEIGHT);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   rem_q,   rem_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic              vld_q,   vld_d;
  logic              done_q,  done_d;
  logic              load;

  // Wraps explicitly so non-power-of-two depths also roll over at HEIGHT-1.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_TOP) ? '0 : a + ADDR_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    // The output register may be refilled when empty or when its current
    // word is being taken at this same edge.
    load    = !vld_q || bus.out_ready;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          rem_d  = bus.length;
          if (bus.length == '0) done_d  = 1'b1;
          else                  state_d = READ;
        end
      end
      READ: begin
        if (load) begin
          data_d = bus.mem_qout;
          vld_d  = 1'b1;
          addr_d = next_addr(addr_q);
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Last word is in the output register; finish once it is taken.
        if (vld_q && bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.mem_read_addr = addr_q;
  assign bus.out_data      = data_q;
  assign bus.out_valid     = vld_q;
endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: a behavioural memory with a
// combinational read port, a clocked write used for the collision case, and
// bursts driven through the interface with hand-computed expected words.
module tb_mem_burst_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] mem [256];
  logic [15:0] got_q [$];

  mem_burst_reader_if #(.WIDTH(16), .HEIGHT(256)) bus ();

  mem_burst_reader #(.WIDTH(16), .HEIGHT(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_qout = mem[bus.mem_read_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_data"},  32'(bus.out_data), 0);
    chk({tag, "_addr"},  32'(bus.mem_read_addr), 0);
  endtask

  // Runs one burst from a negedge. pat gives out_ready for the first plen
  // cycles (then 1). At cycle inj a second start (base 50, len 2) is raised
  // for one cycle. Accepted words land in got_q.
  task automatic run_burst(input string tag, input logic [7:0] b, input logic [8:0] n,
                           input logic [15:0] pat, input int plen, input int inj);
    int          last_hs = -1;
    int          done_at = -1;
    int          dones   = 0;
    bit          any_vld = 0;
    bit          any_bsy = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;
    logic [7:0]  prev_addr = '0;
    got_q.delete();
    bus.start = 1'b1; bus.base_addr = b; bus.length = n; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_lat_addr"}, 32'(bus.mem_read_addr), 32'(b));
    chk({tag, "_lat_busy"}, 32'(bus.busy), (n != 0) ? 1 : 0);
    for (int c = 0; c < 400 && done_at < 0; c++) begin
      bus.out_ready = (c < plen) ? pat[c] : 1'b1;
      if (c == inj) begin
        bus.start = 1'b1; bus.base_addr = 8'd50; bus.length = 9'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_stall_data"},  32'(bus.out_data), 32'(prev_data));
        chk({tag, "_stall_addr"},  32'(bus.mem_read_addr), 32'(prev_addr));
      end
      if (bus.out_valid) any_vld = 1;
      if (bus.busy) any_bsy = 1;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        last_hs = c;
      end
      if (bus.done) begin
        dones++;
        done_at = c;
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_addr  = bus.mem_read_addr;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (done_at < 0) chk({tag, "_timeout"}, 0, 1);
    if (n == 0) begin
      chk({tag, "_z_done_at"}, 32'(done_at), 0);
      chk({tag, "_z_valid"},   32'(any_vld), 0);
      chk({tag, "_z_busy"},    32'(any_bsy), 0);
    end else begin
      chk({tag, "_done_lat"}, 32'(done_at), 32'(last_hs + 1));
    end
    for (int c = 0; c < 3; c++) begin
      if (bus.done) dones++;
      chk({tag, "_post_busy"}, 32'(bus.busy), 0);
      @(negedge clk);
    end
    chk({tag, "_dones"}, 32'(dones), 1);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i + 100);
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic burst: words 104..108 on consecutive cycles.
    run_burst("basic", 8'd4, 9'd5, 16'h0000, 0, -1);
    if (got_q.size() == 5) begin
      chk("basic_w0", 32'(got_q[0]), 104);
      chk("basic_w1", 32'(got_q[1]), 105);
      chk("basic_w2", 32'(got_q[2]), 106);
      chk("basic_w3", 32'(got_q[3]), 107);
      chk("basic_w4", 32'(got_q[4]), 108);
    end

    // Backpressure: ready 1,0,0,1,0,1 (bit c of pat is cycle c).
    run_burst("bp", 8'd0, 9'd3, 16'b10_1001, 6, -1);
    if (got_q.size() == 3) begin
      chk("bp_w0", 32'(got_q[0]), 100);
      chk("bp_w1", 32'(got_q[1]), 101);
      chk("bp_w2", 32'(got_q[2]), 102);
    end

    // Wrap-around: addresses 254,255,0,1.
    run_burst("wrap", 8'd254, 9'd4, 16'h0000, 0, -1);
    if (got_q.size() == 4) begin
      chk("wrap_w0", 32'(got_q[0]), 354);
      chk("wrap_w1", 32'(got_q[1]), 355);
      chk("wrap_w2", 32'(got_q[2]), 100);
      chk("wrap_w3", 32'(got_q[3]), 101);
    end

    // Zero length.
    run_burst("zero", 8'd7, 9'd0, 16'h0000, 0, -1);

    // Second start mid-burst is ignored.
    run_burst("ign", 8'd20, 9'd3, 16'h0000, 0, 1);
    if (got_q.size() == 3) begin
      chk("ign_w0", 32'(got_q[0]), 120);
      chk("ign_w2", 32'(got_q[2]), 122);
    end

    // Full-depth burst from a nonzero base wraps and covers every word once.
    run_burst("full", 8'd200, 9'd256, 16'h0000, 0, -1);
    if (got_q.size() == 256) begin
      chk("full_first", 32'(got_q[0]),   300);
      chk("full_top",   32'(got_q[55]),  355);
      chk("full_zero",  32'(got_q[56]),  100);
      chk("full_last",  32'(got_q[255]), 299);
    end

    // Reset after two of six words.
    bus.start = 1'b1; bus.base_addr = 8'd0; bus.length = 9'd6; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rstmid_w0", 32'(bus.out_data), 100);
    @(negedge clk);
    chk("rstmid_w1", 32'(bus.out_data), 101);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("rstmid");
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_nodone", 32'(bus.done), 0);
    run_burst("after_rst", 8'd10, 9'd2, 16'h0000, 0, -1);
    if (got_q.size() == 2) begin
      chk("after_rst_w0", 32'(got_q[0]), 110);
      chk("after_rst_w1", 32'(got_q[1]), 111);
    end

    // Collision: memory writes the captured address at the capture edge.
    bus.start = 1'b1; bus.base_addr = 8'd30; bus.length = 9'd1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    mem[30] <= 16'hBEEF;
    @(negedge clk);
    chk("coll_valid", 32'(bus.out_valid), 1);
    chk("coll_old",   32'(bus.out_data), 130);
    @(negedge clk);
    chk("coll_done",  32'(bus.done), 1);
    @(negedge clk);
    run_burst("reread", 8'd30, 9'd1, 16'h0000, 0, -1);
    if (got_q.size() == 1) chk("reread_w0", 32'(got_q[0]), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
